vga_text_engine: RTL and testbench

VGA_TEXT_ENGINE -- requirements
Module: vga_text_engine

---
 rtl/vga_text_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_vga_text_engine.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_engine.sv
// Character-cell VGA text renderer: 8-pixel glyphs from an external font ROM,
// per-cell colour attributes, blinking text and an underline cursor.
module vga_text_engine #(
  parameter int COLS         = 80,
  parameter int ROWS         = 40,
  parameter int CHAR_H       = 12,
  parameter int H_VIS        = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_VIS        = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int BLINK_FRAMES = 16,
  parameter int AW           = $clog2(COLS*ROWS)
) (
  input  logic          clk25MHz,
  input  logic          reset,
  input  logic          wren,
  input  logic          wrencolor,
  input  logic [AW-1:0] wraddress,
  input  logic [7:0]    wrdata,
  input  logic [7:0]    wcolor,
  input  logic          wrencursor,
  input  logic [7:0]    wcursor_x,
  input  logic [7:0]    wcursor_y,
  input  logic [1:0]    wcursor_ctl,
  output logic [11:0]   FONT_A,
  input  logic [7:0]    FONT_D,
  output logic [7:0]    R,
  output logic [7:0]    G,
  output logic [7:0]    B,
  output logic          hsync,
  output logic          vsync
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int CELLS = COLS * ROWS;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int FW    = $clog2(BLINK_FRAMES + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VISL = HW'(H_VIS);
  localparam logic [HW-1:0] H_TXT  = HW'(COLS * 8);
  localparam logic [HW-1:0] H_SS   = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VISL = VW'(V_VIS);
  localparam logic [VW-1:0] V_TXT  = VW'(ROWS * CHAR_H);
  localparam logic [VW-1:0] V_SS   = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [3:0]    SL_LAST = 4'(CHAR_H - 1);
  localparam logic [3:0]    SL_CUR  = 4'(CHAR_H - 2);
  localparam logic [FW-1:0] FR_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [AW:0]   CELLS_L = (AW+1)'(CELLS);

  function automatic logic [7:0] expand(input logic b);
    return {8{b}};
  endfunction

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [2:0]    px_q, px_d;
  logic [7:0]    col_q, col_d;
  logic [7:0]    row_q, row_d;
  logic [3:0]    sl_q, sl_d;
  logic [AW-1:0] rbase_q, rbase_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          phase_q, phase_d;
  logic [7:0]    cur_x_q, cur_y_q;
  logic          cur_en_q, cur_blink_q;

  // Cell position tracked incrementally; row base advances by COLS per text row.
  always_comb begin
    h_d     = h_q + HW'(1);
    v_d     = v_q;
    px_d    = px_q + 3'd1;
    col_d   = (px_q == 3'd7) ? col_q + 8'd1 : col_q;
    row_d   = row_q;
    sl_d    = sl_q;
    rbase_d = rbase_q;
    frame_d = frame_q;
    phase_d = phase_q;
    if (h_q == H_LAST) begin
      h_d   = '0;
      px_d  = '0;
      col_d = '0;
      if (v_q == V_LAST) begin
        v_d     = '0;
        sl_d    = '0;
        row_d   = '0;
        rbase_d = '0;
      end else begin
        v_d = v_q + VW'(1);
        if (sl_q == SL_LAST) begin
          sl_d    = '0;
          row_d   = row_q + 8'd1;
          rbase_d = rbase_q + AW'(COLS);
        end else begin
          sl_d = sl_q + 4'd1;
        end
      end
    end
    if (h_q == '0 && v_q == V_VISL) begin
      if (frame_q == FR_LAST) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk25MHz) begin
    if (reset) begin
      h_q         <= '0;
      v_q         <= '0;
      px_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      sl_q        <= '0;
      rbase_q     <= '0;
      frame_q     <= '0;
      phase_q     <= 1'b1;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      cur_en_q    <= 1'b1;
      cur_blink_q <= 1'b1;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      px_q    <= px_d;
      col_q   <= col_d;
      row_q   <= row_d;
      sl_q    <= sl_d;
      rbase_q <= rbase_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      if (wrencursor) begin
        cur_x_q     <= wcursor_x;
        cur_y_q     <= wcursor_y;
        cur_en_q    <= wcursor_ctl[0];
        cur_blink_q <= wcursor_ctl[1];
      end
    end
  end

  // ---- S0: position decode and RAM address ----
  logic [AW-1:0] addr_p0;
  logic          rd_ok_p0, wr_ok, vld_p0, txt_p0, hs_p0, vs_p0, cur_p0;

  always_comb begin
    addr_p0  = rbase_q + AW'(col_q);
    rd_ok_p0 = {1'b0, addr_p0} < CELLS_L;
    wr_ok    = {1'b0, wraddress} < CELLS_L;
    vld_p0   = (h_q < H_VISL) && (v_q < V_VISL);
    txt_p0   = (h_q < H_TXT) && (v_q < V_TXT);
    hs_p0    = !((h_q >= H_SS) && (h_q < H_SE));
    vs_p0    = !((v_q >= V_SS) && (v_q < V_SE));
    cur_p0   = txt_p0 && cur_en_q && (!cur_blink_q || phase_q) &&
               (col_q == cur_x_q) && (row_q == cur_y_q) && (sl_q >= SL_CUR);
  end

  logic [7:0] char_mem [CELLS];
  logic [7:0] attr_mem [CELLS];
  logic [7:0] char_p1, attr_p1, attr_p2;
  logic [3:0] sl_p1;
  logic [2:0] px_p1, px_p2;
  logic       phase_p1, phase_p2;
  logic       vld_p1, txt_p1, hs_p1, vs_p1, cur_p1;
  logic       vld_p2, txt_p2, hs_p2, vs_p2, cur_p2;

  // ---- S1: char/attribute registered, FONT_A driven; S2: FONT_D arrives ----
  always_ff @(posedge clk25MHz) begin
    if (wren && wr_ok)      char_mem[wraddress] <= wrdata;
    if (wrencolor && wr_ok) attr_mem[wraddress] <= wcolor;
    char_p1  <= rd_ok_p0 ? char_mem[addr_p0] : 8'h00;
    attr_p1  <= rd_ok_p0 ? attr_mem[addr_p0] : 8'h00;
    sl_p1    <= sl_q;
    px_p1    <= px_q;
    phase_p1 <= phase_q;
    attr_p2  <= attr_p1;
    px_p2    <= px_p1;
    phase_p2 <= phase_p1;
  end

  assign FONT_A = {char_p1, sl_p1};

  logic       glyph_on_p2, fg_p2, unused_attr_p2;
  logic [2:0] rgb_p2;

  always_comb begin
    glyph_on_p2    = FONT_D[3'd7 - px_p2];
    fg_p2          = cur_p2 | (glyph_on_p2 & ~(attr_p2[7] & ~phase_p2));
    rgb_p2         = 3'b000;
    if (vld_p2 && txt_p2) rgb_p2 = fg_p2 ? attr_p2[2:0] : attr_p2[6:4];
    unused_attr_p2 = attr_p2[3];
  end

  // ---- S3: output registers ----
  always_ff @(posedge clk25MHz) begin
    if (reset) begin
      vld_p1 <= 1'b0; txt_p1 <= 1'b0; cur_p1 <= 1'b0; hs_p1 <= 1'b1; vs_p1 <= 1'b1;
      vld_p2 <= 1'b0; txt_p2 <= 1'b0; cur_p2 <= 1'b0; hs_p2 <= 1'b1; vs_p2 <= 1'b1;
      R      <= 8'h00;
      G      <= 8'h00;
      B      <= 8'h00;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
    end else begin
      vld_p1 <= vld_p0; txt_p1 <= txt_p0; cur_p1 <= cur_p0; hs_p1 <= hs_p0; vs_p1 <= vs_p0;
      vld_p2 <= vld_p1; txt_p2 <= txt_p1; cur_p2 <= cur_p1; hs_p2 <= hs_p1; vs_p2 <= vs_p1;
      R      <= expand(rgb_p2[0]);
      G      <= expand(rgb_p2[1]);
      B      <= expand(rgb_p2[2]);
      hsync  <= hs_p2;
      vsync  <= vs_p2;
    end
  end

endmodule

// File: tb/tb_vga_text_engine.sv
// Directed bench for vga_text_engine on a shrunken raster (80x22 total, 6x3 cells of 8x4)
// so blink and sync behaviour fit in a few thousand cycles.
module tb_vga_text_engine;
  localparam int COLS = 6, ROWS = 3, CHAR_H = 4;
  localparam int AW = $clog2(COLS*ROWS);
  localparam int FRM = 80 * 22;

  logic          clk = 1'b0;
  logic          reset, wren, wrencolor, wrencursor;
  logic [AW-1:0] wraddress;
  logic [7:0]    wrdata, wcolor, wcursor_x, wcursor_y;
  logic [1:0]    wcursor_ctl;
  logic [11:0]   FONT_A;
  logic [7:0]    FONT_D;
  logic [7:0]    R, G, B;
  logic          hsync, vsync;
  int            cyc;
  int            total = 0;
  int            bad = 0;

  vga_text_engine #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_H(CHAR_H),
    .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(16), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .BLINK_FRAMES(2), .AW(AW)
  ) dut (
    .clk25MHz(clk), .reset(reset), .wren(wren), .wrencolor(wrencolor),
    .wraddress(wraddress), .wrdata(wrdata), .wcolor(wcolor),
    .wrencursor(wrencursor), .wcursor_x(wcursor_x), .wcursor_y(wcursor_y),
    .wcursor_ctl(wcursor_ctl), .FONT_A(FONT_A), .FONT_D(FONT_D),
    .R(R), .G(G), .B(B), .hsync(hsync), .vsync(vsync)
  );

  always #20 clk = ~clk;

  // Cycle index since the last reset edge: the DUT is at h=0,v=0 when cyc==0.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [7:0] font_row(input logic [11:0] a);
    if (a[11:4] == 8'h41) return (a[3:0] == 4'd0) ? 8'h80 : 8'h00;
    if (a[11:4] == 8'h42) return 8'hF0;
    return 8'h00;
  endfunction

  always @(posedge clk) FONT_D <= font_row(FONT_A);

  task automatic wait_cyc(input int t);
    int guard = 0;
    while (cyc < t && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != t) begin
      total++; bad++;
      $display("FAIL wait_cyc cyc=%0d want=%0d", cyc, t);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] ch, input logic [7:0] at,
                    input logic we, input logic wc);
    wraddress = a; wrdata = ch; wcolor = at; wren = we; wrencolor = wc;
    @(negedge clk);
    wren = 1'b0; wrencolor = 1'b0;
  endtask

  task automatic set_cursor(input logic [7:0] x, input logic [7:0] y, input logic [1:0] ctl);
    wcursor_x = x; wcursor_y = y; wcursor_ctl = ctl; wrencursor = 1'b1;
    @(negedge clk);
    wrencursor = 1'b0;
  endtask

  task automatic rgb_table(input string name, input int base, input int n,
                           input int ts[8], input logic [23:0] ex[8]);
    for (int i = 0; i < n; i++) begin
      wait_cyc(base + ts[i]);
      total++;
      if ({R, G, B} !== ex[i]) begin
        bad++;
        $display("FAIL %s[%0d] t=%0d rgb=%06h want=%06h", name, i, base + ts[i], {R, G, B}, ex[i]);
      end
    end
  endtask

  task automatic test_reset();
    total++;
    if ({R, G, B, hsync, vsync} !== {24'h0, 2'b11}) begin
      bad++;
      $display("FAIL reset_hold rgbhv=%h want=%h", {R, G, B, hsync, vsync}, {24'h0, 2'b11});
    end
    reset = 1'b0;
    for (int t = 0; t < 3; t++) begin
      wait_cyc(t);
      total++;
      if ({R, G, B, hsync, vsync} !== {24'h0, 2'b11}) begin
        bad++;
        $display("FAIL reset_tail t=%0d rgbhv=%h want=%h", t, {R, G, B, hsync, vsync}, {24'h0, 2'b11});
      end
    end
  endtask

  task automatic test_glyph();
    int          ts[8] = '{3, 4, 43, 47, 53, 83, 248, 0};
    logic [23:0] ex[8] = '{24'hFFFFFF, 24'h0, 24'h00FF00, 24'h0, 24'h0, 24'h0, 24'hFFFFFF, 24'h0};
    rgb_table("glyph", 0, 7, ts, ex);
  endtask

  task automatic test_sync();
    int         ts[11] = '{470, 471, 478, 479, 550, 551, 1442, 1443, 1511, 1602, 1603};
    logic [1:0] ex[11] = '{2'b11, 2'b01, 2'b01, 2'b11, 2'b11, 2'b01, 2'b11, 2'b10, 2'b00, 2'b10, 2'b11};
    for (int i = 0; i < 11; i++) begin
      wait_cyc(ts[i]);
      total++;
      if ({hsync, vsync} !== ex[i]) begin
        bad++;
        $display("FAIL sync[%0d] t=%0d hv=%b want=%b", i, ts[i], {hsync, vsync}, ex[i]);
      end
    end
  endtask

  task automatic test_cursor();
    int          ts[8] = '{248, 770, 930, 931, 0, 0, 0, 0};
    logic [23:0] ex[8] = '{24'h0, 24'h0, 24'hFFFFFF, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
    wait_cyc(1700);
    set_cursor(8'd5, 8'd2, 2'b01);
    rgb_table("cursor", FRM, 4, ts, ex);
    wait_cyc(FRM + 1700);
    set_cursor(8'd5, 8'd2, 2'b11);
  endtask

  task automatic test_blink();
    int          ts[8] = '{331, 335, 930, 0, 0, 0, 0, 0};
    logic [23:0] ex0[8] = '{24'hFF0000, 24'hFF0000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
    logic [23:0] ex1[8] = '{24'h0000FF, 24'hFF0000, 24'hFFFFFF, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
    rgb_table("blink_f2", 2*FRM, 3, ts, ex0);
    rgb_table("blink_f3", 3*FRM, 1, ts, ex0);
    rgb_table("blink_f4", 4*FRM, 3, ts, ex1);
  endtask

  task automatic test_back_to_back();
    int          ts[8] = '{43, 44, 0, 0, 0, 0, 0, 0};
    logic [23:0] ex[8] = '{24'h00FF00, 24'h0000FF, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
    int          tb5[8] = '{331, 0, 0, 0, 0, 0, 0, 0};
    logic [23:0] eb5[8] = '{24'h0000FF, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
    wait_cyc(5*FRM + 40);
    wr(5, 8'h42, 8'h04, 1'b0, 1'b1);
    rgb_table("rdw", 5*FRM, 2, ts, ex);
    wait_cyc(5*FRM + 100);
    wr(2, 8'h42, 8'h01, 1'b1, 1'b1);
    wait_cyc(5*FRM + 110);
    wr(5'd18, 8'h00, 8'h00, 1'b1, 1'b1);
    rgb_table("blink_f5", 5*FRM, 1, tb5, eb5);
    wait_cyc(5*FRM + 1700);
    set_cursor(8'd6, 8'd0, 2'b01);
  endtask

  task automatic test_frame6();
    int          ts[8] = '{3, 19, 243, 331, 930, 0, 0, 0};
    logic [23:0] ex[8] = '{24'hFFFFFF, 24'hFF0000, 24'h0, 24'hFF0000, 24'h0, 24'h0, 24'h0, 24'h0};
    rgb_table("frame6", 6*FRM, 5, ts, ex);
  endtask

  task automatic test_reset_mid();
    int         ts[4] = '{1, 3, 70, 71};
    logic [25:0] ex[4] = '{{24'h0, 2'b11}, {24'hFFFFFF, 2'b11}, {24'h0, 2'b11}, {24'h0, 2'b01}};
    wait_cyc(7*FRM + 830);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({R, G, B, hsync, vsync} !== {24'h0, 2'b11}) begin
      bad++;
      $display("FAIL reset_mid_hold rgbhv=%h want=%h", {R, G, B, hsync, vsync}, {24'h0, 2'b11});
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_cyc(ts[i]);
      total++;
      if ({R, G, B, hsync, vsync} !== ex[i]) begin
        bad++;
        $display("FAIL reset_mid[%0d] t=%0d rgbhv=%h want=%h", i, ts[i], {R, G, B, hsync, vsync}, ex[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; wren = 1'b0; wrencolor = 1'b0; wrencursor = 1'b0;
    wraddress = '0; wrdata = '0; wcolor = '0;
    wcursor_x = '0; wcursor_y = '0; wcursor_ctl = '0;
    repeat (3) @(negedge clk);
    wr(0,  8'h41, 8'h07, 1'b1, 1'b1);
    wr(5,  8'h42, 8'h02, 1'b1, 1'b1);
    wr(7,  8'h42, 8'h9C, 1'b1, 1'b1);
    wr(17, 8'h00, 8'h07, 1'b1, 1'b1);
    test_reset();
    test_glyph();
    test_sync();
    test_cursor();
    test_blink();
    test_back_to_back();
    test_frame6();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
